// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundles the requester handshake, the byte bus and the
// uart-facing signals of uart_tx_arbiter. The arbiter uses the slave modport;
// the requesters and the uart (or a bench) use the master modport.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_byte;
  logic [NUM_REQ-1:0]   gnt;
  logic                 busy;
  logic                 uart_transmit;
  logic [7:0]           uart_tx_byte;
  logic                 uart_is_transmitting;
  logic                 timeout_err;

  modport master (
    output req, req_byte, uart_is_transmitting,
    input  gnt, busy, uart_transmit, uart_tx_byte, timeout_err
  );

  modport slave (
    input  req, req_byte, uart_is_transmitting,
    output gnt, busy, uart_transmit, uart_tx_byte, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart transmitter between
// NUM_REQ byte producers. One byte per grant; after launching a byte the
// arbiter waits for uart_is_transmitting to rise and then fall before it
// arbitrates again. All outputs are registered.
// Optional feature: define UART_ARB_TIMEOUT_EN to abandon a byte whose frame
// never starts within TIMEOUT_CYCLES cycles (timeout_err pulses).
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              Pclk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);
  localparam int LW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_LAUNCH     = 2'd1;
  localparam logic [1:0] S_WAIT_START = 2'd2;
  localparam logic [1:0] S_WAIT_DONE  = 2'd3;

  // Parameter sanity: requester count and 8-bit timeout counter reach.
  generate
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("uart_tx_arbiter: NUM_REQ must be 2..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
      $error("uart_tx_arbiter: TIMEOUT_CYCLES must be 1..256");
    end
  endgenerate

  logic [1:0]         state_q, state_d;
  logic [LW-1:0]      last_q, last_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               xmit_q, xmit_d;
  logic [7:0]         byte_q, byte_d;
  logic               busy_q, busy_d;
`ifdef UART_ARB_TIMEOUT_EN
  logic [7:0]         cnt_q, cnt_d;
  logic               tmo_q, tmo_d;
`endif

  // Per-requester byte lanes as an array so the winner can index them.
  logic [7:0] byte_arr [NUM_REQ];
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign byte_arr[gi] = bus.req_byte[8*gi +: 8];
    end
  endgenerate

  // Round-robin search: first set req starting just after the last winner.
  logic          win_found;
  logic [LW-1:0] win_idx;
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && bus.req[LW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = LW'(cand);
      end
    end
  end

  // Next-state logic; gnt and uart_transmit default low so they pulse once.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = '0;
    xmit_d  = 1'b0;
    byte_d  = byte_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          byte_d  = byte_arr[win_idx];
          gnt_d   = NUM_REQ'(1) << win_idx;
          xmit_d  = 1'b1;
          last_d  = win_idx;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_START;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      S_WAIT_START: begin
        if (bus.uart_is_transmitting) begin
          state_d = S_WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
        end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          // The frame never started: drop the byte, keep last at this winner.
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      S_WAIT_DONE: begin
        if (!bus.uart_is_transmitting) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge Pclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= LW'(NUM_REQ - 1);
      gnt_q   <= '0;
      xmit_q  <= 1'b0;
      byte_q  <= 8'h00;
      busy_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q   <= 8'd0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      xmit_q  <= xmit_d;
      byte_q  <= byte_d;
      busy_q  <= busy_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.uart_transmit = xmit_q;
  assign bus.uart_tx_byte  = byte_q;
  assign bus.busy          = busy_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign bus.timeout_err   = tmo_q;
`else
  assign bus.timeout_err   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of grant vectors, hand-written corner
// sequences (byte hold, mid-frame reset, frame that never starts) and a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int TMO   = 16;
  localparam int NEVER = 32'h7fffffff;

  logic Pclk = 1'b0;
  logic rst;
  always #5 Pclk = ~Pclk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .Pclk (Pclk),
    .rst  (rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: last winner, edge index after which the arbiter is free again,
  // cycle of an expected timeout pulse, and the expected registered outputs.
  int           m_last;
  int           idle_from;
  int           tmo_at;
  logic [N-1:0] exp_gnt;
  logic         exp_tx;
  logic [7:0]   exp_byte;

  // Uart stub: raises is_transmitting a few cycles after a launch, lowers later.
  bit stub_en;
  int stub_phase;
  int stub_wait;

  typedef struct {
    logic [N-1:0]   req;
    logic [8*N-1:0] bytes;
    int             winner;
    logic [7:0]     xbyte;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (((r >> idx) & N'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last     = N - 1;
    idle_from  = cyc;
    tmo_at     = NEVER;
    exp_gnt    = '0;
    exp_tx     = 1'b0;
    exp_byte   = 8'h00;
    stub_phase = 0;
    stub_wait  = 0;
  endtask

  // Evaluated at each active edge with the inputs the DUT sampled there.
  task automatic model_edge();
    exp_gnt = '0;
    exp_tx  = 1'b0;
    if (cyc > idle_from && bus.req != '0) begin
      int w;
      w         = rr_pick(m_last, bus.req);
      exp_gnt   = N'(1) << w;
      exp_tx    = 1'b1;
      exp_byte  = bus.req_byte[8*w +: 8];
      m_last    = w;
      idle_from = NEVER;
      tmo_at    = NEVER;
`ifdef UART_ARB_TIMEOUT_EN
      if (!stub_en) begin
        tmo_at    = cyc + TMO + 1;
        idle_from = tmo_at;
      end
`endif
      $display("grant: cyc=%0d req=%b winner=%0d byte=%h", cyc, bus.req, w, exp_byte);
    end
  endtask

  task automatic stub_drive();
    case (stub_phase)
      1: begin
        if (stub_wait == 0) begin
          bus.uart_is_transmitting = 1'b1;
          stub_phase = 2;
          stub_wait  = int'($urandom_range(5, 1));
        end else stub_wait--;
      end
      2: begin
        if (stub_wait == 0) begin
          bus.uart_is_transmitting = 1'b0;
          stub_phase = 0;
          idle_from  = cyc + 1;
        end else stub_wait--;
      end
      default: ;
    endcase
  endtask

  // One clock: model at the edge, stub just after it, compare at the negedge.
  task automatic step();
    @(posedge Pclk);
    cyc++;
    model_edge();
    #1;
    stub_drive();
    @(negedge Pclk);
    chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
    chk("uart_transmit", 32'(bus.uart_transmit), 32'(exp_tx));
    chk("busy", 32'(bus.busy), 32'(cyc < idle_from));
    chk("uart_tx_byte", 32'(bus.uart_tx_byte), 32'(exp_byte));
    chk("timeout_err", 32'(bus.timeout_err), 32'(cyc == tmo_at));
    if (stub_en && exp_tx) begin
      stub_phase = 1;
      stub_wait  = int'($urandom_range(2, 0));
    end
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 80; t++) begin
      step();
      if (exp_gnt != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL grant_wait cyc=%0d got=no grant want=grant within 80 cycles", cyc);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (cyc < idle_from && t < 100) begin
      step();
      t++;
    end
    if (cyc < idle_from) begin
      checks++;
      errors++;
      $display("FAIL drain cyc=%0d got=still busy want=idle within 100 cycles", cyc);
    end
    step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
    chk({tag, "_xmit"}, 32'(bus.uart_transmit), 32'd0);
    chk({tag, "_byte"}, 32'(bus.uart_tx_byte), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_tmo"}, 32'(bus.timeout_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=no finish want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit           ok;
    int           waitc [N];
    int           maxw;
    logic [N-1:0] rq;

    rst = 1'b1;
    bus.req = '0;
    bus.req_byte = '0;
    bus.uart_is_transmitting = 1'b0;
    stub_en = 1'b1;
    model_reset();

    vecs[0]  = '{4'b0001, 32'h0000_0057, 0, 8'h57};
    vecs[1]  = '{4'b0101, 32'h0043_0041, 2, 8'h43};
    vecs[2]  = '{4'b0101, 32'h0043_0041, 0, 8'h41};
    vecs[3]  = '{4'b0101, 32'h0043_0041, 2, 8'h43};
    vecs[4]  = '{4'b1111, 32'h4443_4241, 3, 8'h44};
    vecs[5]  = '{4'b1111, 32'h4443_4241, 0, 8'h41};
    vecs[6]  = '{4'b1111, 32'h4443_4241, 1, 8'h42};
    vecs[7]  = '{4'b1111, 32'h4443_4241, 2, 8'h43};
    vecs[8]  = '{4'b1111, 32'h4443_4241, 3, 8'h44};
    vecs[9]  = '{4'b0110, 32'h0032_3100, 1, 8'h31};
    vecs[10] = '{4'b1001, 32'h9900_0088, 3, 8'h99};
    vecs[11] = '{4'b0011, 32'h0000_1110, 0, 8'h10};

    repeat (3) @(posedge Pclk);
    @(negedge Pclk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    model_reset();

    // Table-driven grant order.
    for (int v = 0; v < 12; v++) begin
      bus.req      = vecs[v].req;
      bus.req_byte = vecs[v].bytes;
      wait_grant(ok);
      if (ok) begin
        chk($sformatf("vec%0d_gnt", v), 32'(bus.gnt), 32'(N'(1) << vecs[v].winner));
        chk($sformatf("vec%0d_byte", v), 32'(bus.uart_tx_byte), 32'(vecs[v].xbyte));
      end
    end
    bus.req = '0;
    drain();

    // req_byte scrambled while the frame is in flight: tx byte must hold.
    bus.req = 4'b0010;
    bus.req_byte = 32'h0000_A500;
    wait_grant(ok);
    bus.req = '0;
    for (int t = 0; t < 40 && (stub_phase != 0 || cyc < idle_from); t++) begin
      bus.req_byte = {$urandom, $urandom} [8*N-1:0];
      step();
    end
    chk("hold_byte", 32'(bus.uart_tx_byte), 32'h0000_00A5);
    drain();

    // Reset pulsed while waiting for the frame to finish.
    bus.req = 4'b0100;
    bus.req_byte = 32'h003C_0000;
    wait_grant(ok);
    bus.req = '0;
    for (int t = 0; t < 20 && stub_phase != 2; t++) step();
    step();
    chk("in_wait_done_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst_async");
    @(posedge Pclk);
    @(negedge Pclk);
    chk_reset_outputs("midrst_held");
    bus.uart_is_transmitting = 1'b0;
    rst = 1'b0;
    model_reset();
    bus.req = 4'b1000;
    bus.req_byte = 32'h8100_0000;
    wait_grant(ok);
    if (ok) chk("after_rst_gnt", 32'(bus.gnt), 32'h8);
    bus.req = '0;
    drain();

    // Frame that never starts: uart stub stays silent.
    stub_en = 1'b0;
    bus.req = 4'b0001;
    bus.req_byte = 32'h0000_000F;
    wait_grant(ok);
    bus.req = '0;
    repeat (40) step();
`ifdef UART_ARB_TIMEOUT_EN
    chk("timeout_idle", 32'(bus.busy), 32'd0);
    stub_en = 1'b1;
`else
    chk("no_timeout_busy", 32'(bus.busy), 32'd1);
    stub_en = 1'b1;
    stub_phase = 1;
    stub_wait  = 0;
    drain();
`endif
    bus.req = 4'b0010;
    bus.req_byte = 32'h0000_6600;
    wait_grant(ok);
    if (ok) chk("after_stall_gnt", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    drain();

    // Randomized requesters; requesters drop or renew after their grant.
    foreach (waitc[i]) waitc[i] = 0;
    maxw = 0;
    for (int t = 0; t < 1500; t++) begin
      step();
      rq = bus.req;
      for (int i = 0; i < N; i++) begin
        if (bus.gnt != '0 && rq[i] && !bus.gnt[i]) begin
          waitc[i]++;
          if (waitc[i] > maxw) maxw = waitc[i];
        end
        if (exp_gnt[i]) begin
          waitc[i] = 0;
          rq[i] = ($urandom % 2) == 0;
          bus.req_byte[8*i +: 8] = 8'($urandom);
        end else if (!rq[i] && ($urandom % 3) == 0) begin
          rq[i] = 1'b1;
          bus.req_byte[8*i +: 8] = 8'($urandom);
        end
      end
      bus.req = rq;
    end
    chk("starvation_bound", 32'(maxw <= N - 1), 32'd1);
    bus.req = '0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
